// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t   : controller state encoding (IDLE, RUN, DONE)
//   WIDTH     : operand width, tied to the external 32-bit Adder
//   ITER      : iterations per multiply (one per multiplier bit)
//   CNT_W     : iteration counter width
//   LAST_ITER : counter value of the final iteration
package mul_pkg;
    localparam int WIDTH     = 32;
    localparam int ITER      = 32;
    localparam int CNT_W     = 6;
    localparam int LAST_ITER = ITER - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Start/done handshake bundle for mul_seq_ctrl.
//   start        : request a multiply (master -> slave)
//   multiplicand : operand A, captured on the accepted start
//   multiplier   : operand B, captured on the accepted start
//   busy         : high while iterating (slave -> master)
//   done         : one-cycle pulse, product valid
//   product      : 64-bit {HI,LO} result
interface mul_seq_ctrl_if;
    import mul_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 unsigned multiplier controller. Drives an external
// carry-less 32-bit Adder each cycle and shifts its result into {HI,LO}.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : start/operand/busy/done/product handshake (slave side)
//   adder_src_1 : Adder Src_1, always HI
//   adder_src_2 : Adder Src_2, MCAND when LO[0]=1 else 0
//   adder_sum   : Adder adder_out
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_seq_ctrl_if.slave     bus,
    output logic [WIDTH-1:0]  adder_src_1,
    output logic [WIDTH-1:0]  adder_src_2,
    input  logic [WIDTH-1:0]  adder_sum
);
    import mul_pkg::*;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_carry;
    logic               w_last;

    // The Adder has no carry-out; recover it from the operand MSBs and the
    // sum MSB. Carry out of bit 31 happens if both MSBs are set, or if
    // exactly one is set and the sum MSB came out 0 (carry-in propagated).
    function automatic logic carry_out(input logic a31, input logic b31,
                                       input logic s31);
        return (a31 & b31) | ((a31 | b31) & ~s31);
    endfunction

    assign adder_src_1 = r_hi;
    assign adder_src_2 = r_lo[0] ? r_mcand : '0;
    assign w_carry     = carry_out(adder_src_1[WIDTH-1], adder_src_2[WIDTH-1],
                                   adder_sum[WIDTH-1]);
    assign w_last      = (r_cnt == CNT_W'(LAST_ITER));

    assign bus.busy    = (r_state == RUN);
    assign bus.done    = (r_state == DONE);
    assign bus.product = {r_hi, r_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:                   w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_hi    <= '0;
            r_lo    <= bus.multiplier;
            r_mcand <= bus.multiplicand;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            // Right-shift the 65-bit {c,S,LO} window: sum LSB enters LO MSB.
            r_hi    <= {w_carry, adder_sum[WIDTH-1:1]};
            r_lo    <= {adder_sum[0], r_lo[WIDTH-1:1]};
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adder_src_1, adder_src_2, adder_sum;

    int errors = 0;
    int checks = 0;

    mul_seq_ctrl_if bus();

    mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .adder_src_1 (adder_src_1),
        .adder_src_2 (adder_src_2),
        .adder_sum   (adder_sum)
    );

    // Stand-in for the external carry-less 32-bit Adder.
    assign adder_sum = adder_src_1 + adder_src_2;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one multiply and follow it to done. cyc counts cycles after the
    // accepting edge (cycle k+cyc). inj pulses a second start at k+10 and in
    // the DONE cycle; both must be ignored.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inj,
                          output logic [63:0] prod, output int cyc_done,
                          output int nbusy, output bit src2_nz);
        int cyc;
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        step();
        bus.start = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier = $urandom;
        cyc = 1; nbusy = 0; cyc_done = -1; src2_nz = 1'b0; prod = 'x;
        while (cyc <= 40) begin
            if (bus.done) begin
                cyc_done = cyc;
                prod = bus.product;
                break;
            end
            if (bus.busy) nbusy++;
            if (bus.busy && adder_src_2 != 0) src2_nz = 1'b1;
            if (inj && cyc == 10) begin
                bus.start = 1'b1; bus.multiplicand = 2; bus.multiplier = 2;
            end else begin
                bus.start = 1'b0;
            end
            step();
            cyc++;
        end
        if (inj) begin
            bus.start = 1'b1; bus.multiplicand = 2; bus.multiplier = 2;
        end
        step();
        bus.start = 1'b0;
        // k+34: back in IDLE, no repeated done, injected start not accepted
        chk("done_not_consecutive", 64'(bus.done), 64'd0);
        if (inj) chk("inj_start_ignored", 64'(bus.busy), 64'd0);
        if (inj) chk("product_held_after_done", bus.product, prod);
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
        logic [63:0] p; int cd, nb; bit nz;
        run_op(a, b, 1'b0, p, cd, nb, nz);
        chk({tag, "_product"}, p, exp);
        chk({tag, "_done_cycle"}, 64'(cd), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    endtask

    initial begin
        vec_t vecs[5];
        logic [63:0] p;
        int cd, nb;
        bit nz;
        logic [31:0] ra, rb;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[3] = '{32'd0,          32'hDEAD_BEEF,  64'd0};
        vecs[4] = '{32'd6,          32'd7,          64'd42};

        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_product", bus.product, 64'd0);
        chk("rst_src_known", 64'($isunknown({adder_src_1, adder_src_2})), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, p, cd, nb, nz);
            chk($sformatf("vec%0d_product", i), p, vecs[i].exp);
            chk($sformatf("vec%0d_done_cycle", i), 64'(cd), 64'd33);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'd32);
            if (vecs[i].a == 0) chk("zero_mcand_src2", 64'(nz), 64'd0);
        end

        // Starts during RUN and DONE are dropped; a fresh start at k+34 works.
        run_op(32'd7, 32'd9, 1'b1, p, cd, nb, nz);
        chk("ignore_product", p, 64'h3F);
        chk("ignore_done_cycle", 64'(cd), 64'd33);
        chk("ignore_busy_cycles", 64'(nb), 64'd32);
        check_op("after_ignore", 32'd2, 32'd2, 64'd4);

        // Asynchronous reset mid-run at k+15.
        bus.start = 1'b1; bus.multiplicand = 32'h1234; bus.multiplier = 32'h5678;
        step();
        bus.start = 1'b0;
        for (int i = 1; i < 15; i++) step();
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_done", 64'(bus.done), 64'd0);
        chk("async_rst_product", bus.product, 64'd0);
        begin
            bit saw_done = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (bus.done) saw_done = 1'b1;
            end
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 25; i++) begin
                step();
                if (bus.done || bus.busy) saw_done = 1'b1;
            end
            chk("no_done_after_rst", 64'(saw_done), 64'd0);
        end
        check_op("post_rst", 32'd6, 32'd7, 64'd42);

        // Random back-to-back operands against plain 64-bit arithmetic.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 10)
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'd0;
                default: ;
            endcase
            check_op($sformatf("rnd%0d", i), ra, rb, 64'(ra) * 64'(rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
